// File: rtl/spi_reg_access_ctrl_pkg.sv
// Shared types and constants for the SPI register-access sequencer.
//   spi_state_t  : sequencer state encoding
//   CMD_RD_BIT   : command-byte bit selecting read (1) or write (0)
//   BYTE_W       : serial byte width
//   BIT_CNT_W    : width of the in-byte bit counter
//   BYTE_CNT_MAX : saturation value of the per-transaction byte counter
package spi_reg_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ERR   = 2'd3
    } spi_state_t;

    localparam int unsigned CMD_RD_BIT   = 7;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BIT_CNT_W    = 3;
    localparam int unsigned BYTE_CNT_MAX = 255;

endpackage

// File: rtl/spi_reg_access_ctrl_if.sv
// Bus between the SPI sequencer, the MOSI pin and the register file.
//   serial_in : MOSI bit into the sequencer
//   wr_en/wr_addr/wr_data : register-file write strobe and payload
//   rd_load/rd_addr       : POCI load pulse and read-mux select
//   busy/err/byte_cnt     : transaction status
// master = sequencer side, slave = pin/register-file side.
interface spi_reg_access_ctrl_if #(
    parameter int unsigned ADDR_W = 7
) ();
    import spi_reg_access_ctrl_pkg::*;

    logic                serial_in;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [BYTE_W-1:0]   wr_data;
    logic                rd_load;
    logic [ADDR_W-1:0]   rd_addr;
    logic                busy;
    logic                err;
    logic [BYTE_W-1:0]   byte_cnt;

    modport master (
        input  serial_in,
        output wr_en, wr_addr, wr_data, rd_load, rd_addr, busy, err, byte_cnt
    );

    modport slave (
        output serial_in,
        input  wr_en, wr_addr, wr_data, rd_load, rd_addr, busy, err, byte_cnt
    );
endinterface

// File: rtl/spi_reg_access_ctrl_byte_deser.sv
// MOSI byte deserializer: MSB-first shift register plus free-running bit counter.
//   sclk, rstn    : clock / async active-low reset
//   serial_in     : MOSI bit, sampled on posedge sclk
//   byte_c        : assembled byte, valid on the edge where byte_valid_c=1
//   byte_valid_c  : high during the cycle whose posedge captures the 8th bit
module spi_reg_access_ctrl_byte_deser
    import spi_reg_access_ctrl_pkg::*;
(
    input  logic              sclk,
    input  logic              rstn,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] byte_c,
    output logic              byte_valid_c
);

    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BYTE_W-2:0]    shift_q;

    // Bit counter wraps naturally every byte; a partial byte is lost on reset.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            shift_q   <= {shift_q[BYTE_W-3:0], serial_in};
        end
    end

    // The 8th bit is taken straight from the pin so the byte is usable on its own edge.
    assign byte_valid_c = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
    assign byte_c       = {shift_q, serial_in};

endmodule

// File: rtl/spi_reg_access_ctrl.sv
// SPI transaction sequencer: first byte is a command, following bytes become
// register-file write strobes or POCI read loads with an auto-incrementing address.
//   sclk, rstn : SPI clock / combined async active-low reset (every transaction starts in IDLE)
//   bus        : master modport of spi_reg_access_ctrl_if (MOSI in, register-file strobes
//                and status out; all outputs registered)
// Parameters: ADDR_W address width, NUM_REGS implemented registers,
//             WRAP 1 = address wraps to 0 past the last register, 0 = error.
module spi_reg_access_ctrl
    import spi_reg_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned NUM_REGS = 64,
    parameter bit          WRAP     = 1'b1
) (
    input  logic                  sclk,
    input  logic                  rstn,
    spi_reg_access_ctrl_if.master bus
);

    logic [BYTE_W-1:0] byte_c;
    logic              byte_valid_c;

    spi_reg_access_ctrl_byte_deser u_deser (
        .sclk         (sclk),
        .rstn         (rstn),
        .serial_in    (bus.serial_in),
        .byte_c       (byte_c),
        .byte_valid_c (byte_valid_c)
    );

    spi_state_t state_q, state_nxt;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              rd_load_q, rd_load_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;

    // Command decode and address stepping (increment is modulo 2^ADDR_W before the range check).
    logic              cmd_rd_c;
    logic [ADDR_W-1:0] cmd_addr_c;
    logic              cmd_bad_c;
    logic [ADDR_W-1:0] addr_step_c;
    logic              past_end_c;
    logic [ADDR_W-1:0] next_addr_c;
    logic              step_err_c;

    assign cmd_rd_c    = byte_c[CMD_RD_BIT];
    assign cmd_addr_c  = byte_c[ADDR_W-1:0];
    assign cmd_bad_c   = (32'(cmd_addr_c) >= 32'(NUM_REGS));
    assign addr_step_c = addr_q + ADDR_W'(1);
    assign past_end_c  = (32'(addr_step_c) >= 32'(NUM_REGS));
    assign next_addr_c = past_end_c ? '0 : addr_step_c;
    assign step_err_c  = past_end_c && !WRAP;

    // State register.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; only byte boundaries move the FSM.
    always_comb begin
        state_nxt = state_q;
        if (byte_valid_c) begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_bad_c)     state_nxt = ERR;
                    else if (cmd_rd_c) state_nxt = READ;
                    else               state_nxt = WRITE;
                end
                WRITE:   if (ovf_q)      state_nxt = ERR;
                READ:    if (step_err_c) state_nxt = ERR;
                ERR:     state_nxt = ERR;
                default: state_nxt = ERR;
            endcase
        end
    end

    // Output / datapath next values.
    // A write steps its address after the strobe, so an overrun is remembered in ovf
    // and only faults when the next data byte arrives; a read steps before loading.
    always_comb begin
        wr_en_d    = 1'b0;
        rd_load_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = (state_nxt != IDLE);

        if (byte_valid_c) begin
            if (byte_cnt_q != BYTE_W'(BYTE_CNT_MAX)) begin
                byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    addr_d = cmd_addr_c;
                    ovf_d  = 1'b0;
                    if (cmd_bad_c) begin
                        err_d = 1'b1;
                    end else if (cmd_rd_c) begin
                        rd_addr_d = cmd_addr_c;
                        rd_load_d = 1'b1;
                    end
                end
                WRITE: begin
                    if (ovf_q) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = byte_c;
                        addr_d    = next_addr_c;
                        ovf_d     = step_err_c;
                    end
                end
                READ: begin
                    if (step_err_c) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = next_addr_c;
                        rd_addr_d = next_addr_c;
                        rd_load_d = 1'b1;
                    end
                end
                ERR:     err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_load_q  <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_load_q  <= rd_load_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_load  = rd_load_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Self-checking bench for spi_reg_access_ctrl. Two instances share one MOSI stream:
// dut_a (WRAP=1) is checked by a strobe scoreboard, dut_b (WRAP=0) by the wrap/reset tasks.
module tb_spi_reg_access_ctrl;

    localparam int unsigned AW = 7;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_exp_t;

    logic sclk;
    logic rstn;

    spi_reg_access_ctrl_if #(.ADDR_W(AW)) bus_a ();
    spi_reg_access_ctrl_if #(.ADDR_W(AW)) bus_b ();

    spi_reg_access_ctrl #(.ADDR_W(AW), .NUM_REGS(64), .WRAP(1'b1)) dut_a (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus_a.master)
    );

    spi_reg_access_ctrl #(.ADDR_W(AW), .NUM_REGS(64), .WRAP(1'b0)) dut_b (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus_b.master)
    );

    int total = 0;
    int bad   = 0;

    wr_exp_t       wq[$];
    logic [AW-1:0] rq[$];

    logic          prev_strobe = 1'b0;
    int            b_wr_cnt    = 0;
    logic [AW-1:0] b_last_addr = '0;

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for dut_a, sampled 1 time unit after each posedge.
    always @(posedge sclk) begin
        #1;
        if (rstn) begin
            if (bus_a.wr_en || bus_a.rd_load) begin
                total++;
                if (bus_a.wr_en && bus_a.rd_load) begin
                    bad++;
                    $display("FAIL strobe_excl: wr_en=%0b rd_load=%0b both high", bus_a.wr_en, bus_a.rd_load);
                end
                total++;
                if (prev_strobe) begin
                    bad++;
                    $display("FAIL strobe_gap: strobe on consecutive cycles at %0t", $time);
                end
            end
            if (bus_a.wr_en) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wr: addr=%h data=%h, none expected", bus_a.wr_addr, bus_a.wr_data);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    if (bus_a.wr_addr !== e.addr || bus_a.wr_data !== e.data) begin
                        bad++;
                        $display("FAIL wr_payload: got addr=%h data=%h, want addr=%h data=%h",
                                 bus_a.wr_addr, bus_a.wr_data, e.addr, e.data);
                    end
                end
            end
            if (bus_a.rd_load) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rd: rd_addr=%h, none expected", bus_a.rd_addr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = rq.pop_front();
                    if (bus_a.rd_addr !== ea) begin
                        bad++;
                        $display("FAIL rd_addr: got %h want %h", bus_a.rd_addr, ea);
                    end
                end
            end
            prev_strobe = bus_a.wr_en || bus_a.rd_load;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Write-strobe tally for the non-wrapping instance.
    always @(posedge sclk) begin
        #1;
        if (rstn && bus_b.wr_en) begin
            b_wr_cnt++;
            b_last_addr = bus_b.wr_addr;
        end
    end

    // Reset both DUTs, then release on a negedge so the next posedge samples bit 7 of byte 0.
    task automatic begin_txn();
        @(negedge sclk);
        rstn = 1'b0;
        repeat (2) @(negedge sclk);
        wq.delete();
        rq.delete();
        b_wr_cnt = 0;
        rstn = 1'b1;
    endtask

    // Drive nbits of b, MSB first; returns on the negedge after the last sampled bit.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus_a.serial_in = b[i];
            bus_b.serial_in = b[i];
            @(negedge sclk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    // Every expected strobe must have been consumed by the monitor.
    task automatic check_drained(input string name);
        total++;
        if (wq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d writes and %0d reads still pending, want 0 and 0",
                     name, wq.size(), rq.size());
        end
    endtask

    task automatic test_reset();
        @(negedge sclk);
        rstn = 1'b0;
        repeat (3) @(negedge sclk);
        total++;
        if ({bus_a.wr_en, bus_a.rd_load, bus_a.busy, bus_a.err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: wr_en,rd_load,busy,err=%b want 0000",
                     {bus_a.wr_en, bus_a.rd_load, bus_a.busy, bus_a.err});
        end
        total++;
        if (bus_a.byte_cnt !== 8'd0 || bus_a.wr_addr !== 7'd0 || bus_a.rd_addr !== 7'd0 || bus_a.wr_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_values: byte_cnt=%h wr_addr=%h rd_addr=%h wr_data=%h want all 0",
                     bus_a.byte_cnt, bus_a.wr_addr, bus_a.rd_addr, bus_a.wr_data);
        end
        total++;
        if (bus_b.err !== 1'b0 || bus_b.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: err=%b busy=%b want 0 0", bus_b.err, bus_b.busy);
        end
    endtask

    task automatic test_write();
        begin_txn();
        wq.push_back('{addr: 7'h05, data: 8'hA1});
        wq.push_back('{addr: 7'h06, data: 8'hB2});
        send_byte(8'h05);
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.byte_cnt !== 8'd1) begin
            bad++;
            $display("FAIL write_cmd: busy=%b byte_cnt=%0d want 1 1", bus_a.busy, bus_a.byte_cnt);
        end
        send_byte(8'hA1);
        send_byte(8'hB2);
        check_drained("write");
        total++;
        if (bus_a.byte_cnt !== 8'd3 || bus_a.err !== 1'b0) begin
            bad++;
            $display("FAIL write_status: byte_cnt=%0d err=%b want 3 0", bus_a.byte_cnt, bus_a.err);
        end
    endtask

    task automatic test_read();
        begin_txn();
        rq.push_back(7'h03);
        rq.push_back(7'h04);
        rq.push_back(7'h05);
        send_byte(8'h83);
        send_byte(8'h00);
        send_byte(8'hFF);
        check_drained("read");
        total++;
        if (bus_a.byte_cnt !== 8'd3 || bus_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL read_status: byte_cnt=%0d busy=%b want 3 1", bus_a.byte_cnt, bus_a.busy);
        end
    endtask

    task automatic test_wrap();
        begin_txn();
        wq.push_back('{addr: 7'h3F, data: 8'h11});
        wq.push_back('{addr: 7'h00, data: 8'h22});
        send_byte(8'h3F);
        send_byte(8'h11);
        total++;
        if (b_wr_cnt != 1 || b_last_addr !== 7'h3F || bus_b.err !== 1'b0) begin
            bad++;
            $display("FAIL nowrap_first: writes=%0d addr=%h err=%b want 1 3f 0",
                     b_wr_cnt, b_last_addr, bus_b.err);
        end
        send_byte(8'h22);
        check_drained("wrap");
        total++;
        if (bus_b.err !== 1'b1 || b_wr_cnt != 1) begin
            bad++;
            $display("FAIL nowrap_err: err=%b writes=%0d want 1 1", bus_b.err, b_wr_cnt);
        end
        total++;
        if (bus_a.err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_noerr: err=%b want 0", bus_a.err);
        end
        // Non-wrapping read stepping off the end faults without a second load.
        begin_txn();
        rq.push_back(7'h3F);
        rq.push_back(7'h00);
        send_byte(8'hBF);
        send_byte(8'h00);
        check_drained("wrap_read");
        total++;
        if (bus_b.err !== 1'b1 || bus_a.rd_addr !== 7'h00) begin
            bad++;
            $display("FAIL wrap_read: b.err=%b a.rd_addr=%h want 1 00", bus_b.err, bus_a.rd_addr);
        end
    endtask

    task automatic test_bad_addr();
        begin_txn();
        send_byte(8'h50);
        total++;
        if (bus_a.err !== 1'b1 || bus_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL bad_cmd: err=%b busy=%b want 1 1", bus_a.err, bus_a.busy);
        end
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check_drained("bad_addr");
        total++;
        if (bus_a.byte_cnt !== 8'd4 || bus_a.err !== 1'b1) begin
            bad++;
            $display("FAIL bad_status: byte_cnt=%0d err=%b want 4 1", bus_a.byte_cnt, bus_a.err);
        end
    endtask

    task automatic test_mid_byte_reset();
        begin_txn();
        send_byte(8'h10);
        send_bits(8'hC3, 5);
        total++;
        if (bus_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL midbyte_pre: busy=%b want 1", bus_a.busy);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (bus_a.busy !== 1'b0 || bus_a.byte_cnt !== 8'd0 || bus_a.wr_en !== 1'b0 || bus_a.err !== 1'b0) begin
            bad++;
            $display("FAIL midbyte_reset: busy=%b byte_cnt=%0d wr_en=%b err=%b want 0 0 0 0",
                     bus_a.busy, bus_a.byte_cnt, bus_a.wr_en, bus_a.err);
        end
        begin_txn();
        rq.push_back(7'h02);
        send_byte(8'h82);
        check_drained("midbyte_cmd");
        total++;
        if (bus_a.byte_cnt !== 8'd1 || bus_a.rd_addr !== 7'h02) begin
            bad++;
            $display("FAIL midbyte_cmd: byte_cnt=%0d rd_addr=%h want 1 02", bus_a.byte_cnt, bus_a.rd_addr);
        end
    endtask

    task automatic test_reset_during_wr_en();
        begin_txn();
        wq.push_back('{addr: 7'h3F, data: 8'h01});
        wq.push_back('{addr: 7'h00, data: 8'h02});
        send_byte(8'h3F);
        send_byte(8'h01);
        send_byte(8'h02);
        check_drained("rst_wr");
        total++;
        if (bus_a.wr_en !== 1'b1 || bus_b.err !== 1'b1) begin
            bad++;
            $display("FAIL rst_wr_pre: a.wr_en=%b b.err=%b want 1 1", bus_a.wr_en, bus_b.err);
        end
        #1;
        rstn = 1'b0;
        #1;
        total++;
        if (bus_a.wr_en !== 1'b0 || bus_a.byte_cnt !== 8'd0 || bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_wr_async: wr_en=%b byte_cnt=%0d busy=%b want 0 0 0",
                     bus_a.wr_en, bus_a.byte_cnt, bus_a.busy);
        end
        total++;
        if (bus_b.err !== 1'b0 || bus_b.byte_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_err_clear: err=%b byte_cnt=%0d want 0 0", bus_b.err, bus_b.byte_cnt);
        end
    endtask

    initial begin
        rstn            = 1'b0;
        bus_a.serial_in = 1'b0;
        bus_b.serial_in = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_addr();
        test_mid_byte_reset();
        test_reset_during_wr_en();
        @(negedge sclk);
        rstn = 1'b0;
        repeat (2) @(negedge sclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
